// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises rx_in, frames start/data/stop bits on clk_bps pulses.
// Optional parity (state PARITY, parity_err strobe) compiled in with `define UART_PARITY_EN.
module uart_rx_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic                 clk_bps,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err
);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam int         IW   = $clog2(DATA_BITS);
    localparam logic [3:0] LAST = 4'(DATA_BITS - 1);

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s, rx_prev, fall;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_bad;
    logic                   start_frame, end_frame, shift_en, cnt_clr;
    logic                   good, ferr, perr;

    assign rx_s = sync[SYNC_STAGES-1];
    assign fall = rx_prev & ~rx_s;

`ifdef UART_PARITY_EN
    logic par_bit, par_cap;
    assign par_bad = par_bit ^ (^shift_reg) ^ 1'(PARITY_ODD);

    always_ff @(posedge clk) begin
        if (rst)          par_bit <= 1'b0;
        else if (par_cap) par_bit <= rx_s;
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], rx_in};
            rx_prev <= rx_s;
        end
    end

    always_comb begin
        state_n     = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        shift_en    = 1'b0;
        cnt_clr     = 1'b0;
        good        = 1'b0;
        ferr        = 1'b0;
        perr        = 1'b0;
`ifdef UART_PARITY_EN
        par_cap     = 1'b0;
`endif
        case (state)
            IDLE: if (fall) begin
                state_n     = START;
                start_frame = 1'b1;
            end
            START: if (clk_bps) begin
                if (!rx_s) begin
                    state_n = DATA;
                    cnt_clr = 1'b1;
                end else begin
                    state_n   = IDLE;
                    end_frame = 1'b1;
                end
            end
            DATA: if (clk_bps) begin
                shift_en = 1'b1;
`ifdef UART_PARITY_EN
                if (bit_cnt == LAST) state_n = PARITY;
`else
                if (bit_cnt == LAST) state_n = STOP;
`endif
            end
`ifdef UART_PARITY_EN
            PARITY: if (clk_bps) begin
                par_cap = 1'b1;
                state_n = STOP;
            end
`endif
            STOP: if (clk_bps) begin
                state_n   = IDLE;
                end_frame = 1'b1;
                // frame error wins over parity error so the two never strobe together
                if (!rx_s)        ferr = 1'b1;
                else if (par_bad) perr = 1'b1;
                else              good = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bps_start  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
        end else begin
            state      <= state_n;
            rx_valid   <= good;
            frame_err  <= ferr;
            parity_err <= perr;
            if (start_frame)    bps_start <= 1'b1;
            else if (end_frame) bps_start <= 1'b0;
            if (cnt_clr)                          bit_cnt <= '0;
            else if (shift_en && bit_cnt != LAST) bit_cnt <= bit_cnt + 4'd1;
            if (shift_en) shift_reg[bit_cnt[IW-1:0]] <= rx_s;
            if (good)     rx_data <= shift_reg;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a behavioural baud divider and frame-level model.
// Define UART_PARITY_EN for both files to exercise the parity build.
module tb_uart_rx_ctrl;

    localparam int BIT  = 32;
    localparam int HALF = 16;
    localparam int PODD = 0;
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       clk_bps;
    logic       bps_start;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2), .PARITY_ODD(PODD)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .clk_bps(clk_bps),
        .bps_start(bps_start), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_err(frame_err), .parity_err(parity_err)
    );

    always #10 clk = ~clk;

    int unsigned div_cnt = 0;
    always @(posedge clk) begin
        if (!bps_start)          div_cnt <= 0;
        else if (div_cnt == BIT - 1) div_cnt <= 0;
        else                     div_cnt <= div_cnt + 1;
    end
    assign clk_bps = bps_start && (div_cnt == HALF);

    int         n_valid = 0, n_ferr = 0, n_perr = 0, n_rise = 0, n_both = 0;
    logic       bps_prev = 1'b0, valid_bps = 1'b1, valid_bps_prev = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(rx_data);
            n_valid        <= n_valid + 1;
            valid_bps      <= bps_start;
            valid_bps_prev <= bps_prev;
        end
        if (frame_err)  n_ferr <= n_ferr + 1;
        if (parity_err) n_perr <= n_perr + 1;
        if (rx_valid && (frame_err || parity_err)) n_both <= n_both + 1;
        if (bps_start && !bps_prev) n_rise <= n_rise + 1;
        bps_prev <= bps_start;
    end

    logic [7:0] exp_data = 8'h00;

    // 0 = good byte, 1 = frame error, 2 = parity error
    function automatic int expect_kind(logic [7:0] d, logic par, logic stop);
        if (!stop) return 1;
        if (PAR_EN && (par !== ((^d) ^ 1'(PODD)))) return 2;
        return 0;
    endfunction

    function automatic logic good_par(logic [7:0] d);
        return (^d) ^ 1'(PODD);
    endfunction

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par);
        drive_bit(stop);
    endtask

    // sends one frame and compares strobe counts and data against the model
    task automatic frame_check(input string name, input logic [7:0] d, input logic par,
                               input logic stop);
        int v0, f0, p0, q0, kind;
        v0 = n_valid; f0 = n_ferr; p0 = n_perr; q0 = got_q.size();
        kind = expect_kind(d, par, stop);
        send_frame(d, par, stop);
        if (kind == 0) exp_data = d;
        n_checks++;
        if ((n_valid - v0) !== ((kind == 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s rx_valid pulses: got %0d expected %0d", name, n_valid - v0, (kind == 0) ? 1 : 0);
        end
        n_checks++;
        if ((n_ferr - f0) !== ((kind == 1) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s frame_err pulses: got %0d expected %0d", name, n_ferr - f0, (kind == 1) ? 1 : 0);
        end
        n_checks++;
        if ((n_perr - p0) !== ((kind == 2) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s parity_err pulses: got %0d expected %0d", name, n_perr - p0, (kind == 2) ? 1 : 0);
        end
        n_checks++;
        if (rx_data !== exp_data) begin
            n_fail++;
            $display("FAIL %s rx_data: got %02h expected %02h", name, rx_data, exp_data);
        end
        if (kind == 0 && got_q.size() > q0) begin
            n_checks++;
            if (got_q[q0] !== d) begin
                n_fail++;
                $display("FAIL %s strobed data: got %02h expected %02h", name, got_q[q0], d);
            end
        end
    endtask

    task automatic test_reset;
        int r0;
        rst = 1'b1; rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bps_start, rx_data, rx_valid, frame_err, parity_err} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset outputs: got %03h expected 000", {bps_start, rx_data, rx_valid, frame_err, parity_err});
        end
        rst = 1'b0;
        r0 = n_rise;
        repeat (2000) @(posedge clk);
        #1;
        n_checks++;
        if ((n_rise - r0) !== 0 || bps_start !== 1'b0) begin
            n_fail++;
            $display("FAIL idle bps_start: got %0d rises expected 0", n_rise - r0);
        end
    endtask

    task automatic test_basic;
        frame_check("frame_a5", 8'hA5, good_par(8'hA5), 1'b1);
        n_checks++;
        if (valid_bps !== 1'b0 || valid_bps_prev !== 1'b1) begin
            n_fail++;
            $display("FAIL bps_at_valid: got %b%b expected 10", valid_bps_prev, valid_bps);
        end
        idle(20);
    endtask

    task automatic test_back_to_back;
        int q0;
        q0 = got_q.size();
        frame_check("b2b_00", 8'h00, good_par(8'h00), 1'b1);
        frame_check("b2b_ff", 8'hFF, good_par(8'hFF), 1'b1);
        n_checks++;
        if (got_q.size() - q0 !== 2) begin
            n_fail++;
            $display("FAIL b2b count: got %0d expected 2", got_q.size() - q0);
        end else begin
            n_checks++;
            if ({got_q[q0], got_q[q0+1]} !== 16'h00FF) begin
                n_fail++;
                $display("FAIL b2b order: got %02h %02h expected 00 ff", got_q[q0], got_q[q0+1]);
            end
        end
        idle(20);
    endtask

    task automatic test_glitch;
        int r0, s0;
        r0 = n_rise; s0 = n_valid + n_ferr + n_perr;
        rx_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        idle(2 * BIT);
        n_checks++;
        if ((n_rise - r0) !== 1 || bps_start !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch bps: got %0d rises, bps=%b expected 1 rise, bps=0", n_rise - r0, bps_start);
        end
        n_checks++;
        if ((n_valid + n_ferr + n_perr - s0) !== 0) begin
            n_fail++;
            $display("FAIL glitch strobes: got %0d expected 0", n_valid + n_ferr + n_perr - s0);
        end
    endtask

    task automatic test_frame_err;
        frame_check("frame_err_3c", 8'h3C, good_par(8'h3C), 1'b0);
        idle(20);
    endtask

    task automatic test_break;
        int f0, v0;
        f0 = n_ferr; v0 = n_valid;
        rx_in = 1'b0;
        repeat (15 * BIT) @(posedge clk);
        #1;
        n_checks++;
        if ((n_ferr - f0) !== 1 || (n_valid - v0) !== 0 || bps_start !== 1'b0) begin
            n_fail++;
            $display("FAIL break: got ferr=%0d valid=%0d bps=%b expected 1 0 0", n_ferr - f0, n_valid - v0, bps_start);
        end
        idle(20);
        frame_check("after_break", 8'h5A, good_par(8'h5A), 1'b1);
        idle(10);
    endtask

    task automatic test_parity;
        frame_check("parity_bad_07", 8'h07, 1'b0, 1'b1);
        idle(10);
        frame_check("parity_ok_07", 8'h07, 1'b1, 1'b1);
        idle(10);
    endtask

    task automatic test_reset_midframe;
        int s0;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        s0 = n_valid + n_ferr + n_perr;
        rst = 1'b1; rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_data = 8'h00;
        idle(12 * BIT);
        n_checks++;
        if ((n_valid + n_ferr + n_perr - s0) !== 0 || bps_start !== 1'b0 || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_midframe: got strobes=%0d bps=%b data=%02h expected 0 0 00", n_valid + n_ferr + n_perr - s0, bps_start, rx_data);
        end
        frame_check("after_reset", 8'hC3, good_par(8'hC3), 1'b1);
        idle(10);
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic       par, stop;
        int         gap;
        for (int k = 0; k < 24; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            par  = good_par(d);
            if ($urandom_range(0, 3) == 0) par = ~par;
            gap  = $urandom_range(0, 20);
            if (!stop && gap < 4) gap = 4;
            frame_check("random", d, par, stop);
            if (gap > 0) idle(gap);
        end
        n_checks++;
        if (n_both !== 0) begin
            n_fail++;
            $display("FAIL strobe overlap: got %0d expected 0", n_both);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_break;
        if (PAR_EN) test_parity;
        test_reset_midframe;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
